data_pack: RTL
==============

# data_pack

Parametrised input-word packer: accumulates LANES consecutive IN_W-bit beats into one LANES*IN_W-bit output word, with alignment restart, partial-word flush with per-lane keep mask, and valid/ready backpressure on the output. It sits between a narrow ADC/sample stream and wide buffer/FIFO writers in the dscope capture path. It is the generalised replacement for the fixed 8-to-32 packer: any width and ratio, plus flush and backpressure.

## Interface
- IN_W, 8, input beat width in bits (>=1)
- LANES, 4, beats per output word (>=2)
- MSB_FIRST, 1, 1: first accepted beat lands in the most significant lane; 0: in lane 0 (LSBs)
- PAD, 0, IN_W-bit value written into unfilled lanes on flush
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_sync  in  1  restart alignment; discards the partial word
- i_flush  in  1  emit the partial word, if any, padded
- i_data  in  IN_W  input beat
- i_wren  in  1  input beat valid
- o_in_rdy  out  1  packer can accept a beat this cycle
- o_out_data  out  IN_W*LANES  packed word (registered)
- o_out_keep  out  LANES  1 = lane holds real data, in the same lane order as data
- o_out_vld  out  1  output word valid
- i_out_rdy  in  1  downstream accepts word
- o_lane_cnt  out  $clog2(LANES+1)  beats currently held in the accumulator

## Operation
- Accumulator: (LANES-1)*IN_W bits plus a lane counter, 0..LANES-1.
- Beat accepted when i_wren && o_in_rdy && !i_sync.
- o_in_rdy = !o_out_vld || i_out_rdy, combinational.
- Accepted beat with counter < LANES-1: stored in lane `counter` (MSB_FIRST maps lane 0 to bits [IN_W*LANES-1 -: IN_W]); counter increments.
- Accepted beat with counter == LANES-1: the accumulator and the beat load the output register; keep = all ones; counter goes to 0.
- i_flush with no completing beat and effective count > 0: the output register loads the held lanes; unfilled lanes = PAD and keep = 0; counter goes to 0. Effective count includes a beat accepted the same cycle.
- i_flush with effective count 0 has no effect. A flush on a completing beat yields a normal full word.
- i_flush is only acted on when o_in_rdy = 1. Otherwise it is ignored, and the source must hold it.
- i_sync has priority over i_wren and i_flush:
  - counter goes to 0; accumulator contents are don't-care.
  - The beat on that cycle is dropped.
  - The output register and o_out_vld are unaffected.
- Output register: o_out_vld set on load and cleared on o_out_vld && i_out_rdy with no new load. Load and drain in the same cycle keeps o_out_vld = 1 with the new word.

## Timing
- Reset values: o_out_data 0, o_out_keep 0, o_out_vld 0, o_lane_cnt 0, counter 0, accumulator 0. o_in_rdy resets to 1.
- Latency: completing beat or flush at edge N gives o_out_vld = 1 after edge N.
- Throughput: one beat per cycle sustained while i_out_rdy = 1. Full rate is one word per LANES cycles.
- With o_out_vld = 1 and i_out_rdy = 0, o_in_rdy = 0 and beats stall. The partial accumulator is held, not lost.
- Reset asserted mid-word: all state clears immediately; the partial word and any pending output are discarded.
- Counter wraps LANES-1 -> 0 only on a completing beat, flush, or sync.

## Configuration
- DATA_PACK_STAT_EN defined: adds o_word_cnt (out, 16 bits) and o_flush_cnt (out, 16 bits).
  - o_word_cnt counts full words loaded; o_flush_cnt counts partial words loaded.
  - Both wrap at 16 bits and reset to 0 on rst.
  - i_sync does not clear them.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- IN_W=8, LANES=4, MSB_FIRST=1, i_out_rdy=1; beats 0x11,0x22,0x33,0x44 -> one cycle after the 4th beat o_out_data=0x11223344, keep=4'hF, o_out_vld pulses one cycle.
- MSB_FIRST=0, same beats -> o_out_data=0x44332211.
- Beats 0xAA,0xBB then i_flush, PAD=0xEE, MSB_FIRST=1 -> 0xAABBEEEE, keep=4'b1100; o_lane_cnt returns to 0.
- Beats 0x01,0x02, then i_sync together with i_wren of 0x03, then 0x04,0x05,0x06,0x07 -> only 0x04050607 is emitted; the beat 0x03 is dropped.
- i_out_rdy=0 with a word pending; drive 8 beats -> o_in_rdy=0 and no beats accepted. Raise i_out_rdy -> the pending word drains, then 2 words follow in order with nothing lost.
- Assert rst with o_lane_cnt=3 and o_out_vld=1 -> all outputs 0 and o_in_rdy=1 immediately. With DATA_PACK_STAT_EN, check o_word_cnt / o_flush_cnt totals after the flush scenario (1 / 1).

Source files
------------

// File: rtl/data_pack.sv
// data_pack
// ---------------------------------------------------------------------------
// Input-word packer for the dscope capture path. It collects LANES
// consecutive IN_W-bit beats from a narrow sample stream and emits them as
// one IN_W*LANES-bit word for the wide buffer/FIFO writers downstream.
//
// Beyond plain packing it provides:
//   - alignment restart (i_sync), which discards any partial word
//   - partial-word flush (i_flush), with PAD in the unfilled lanes and a
//     per-lane keep mask
//   - valid/ready backpressure on the output word
//
// Parameters
//   IN_W       input beat width in bits (>= 1)
//   LANES      beats per output word (>= 2)
//   MSB_FIRST  1: the first beat of a word lands in the most significant
//              lane; 0: it lands in lane 0 (the LSBs)
//   PAD        IN_W-bit value written into unfilled lanes on a flush
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   i_sync      restart alignment; drops the partial word and this beat
//   i_flush     emit the partial word (if any), padded
//   i_data      input beat
//   i_wren      input beat valid
//   o_in_rdy    packer can accept a beat this cycle (combinational)
//   o_out_data  packed output word (registered)
//   o_out_keep  1 = lane holds real data; same lane order as o_out_data
//   o_out_vld   output word valid
//   i_out_rdy   downstream accepts the output word
//   o_lane_cnt  beats currently held in the accumulator
//
// Optional build macro
//   DATA_PACK_STAT_EN  adds o_word_cnt and o_flush_cnt, two 16-bit wrapping
//                      counters of full and partial words loaded. i_sync
//                      does not clear them.
// ---------------------------------------------------------------------------
module data_pack #(
    parameter int              IN_W      = 8,
    parameter int              LANES     = 4,
    parameter int              MSB_FIRST = 1,
    parameter logic [IN_W-1:0] PAD       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_sync,
    input  logic                       i_flush,
    input  logic [IN_W-1:0]            i_data,
    input  logic                       i_wren,
    output logic                       o_in_rdy,
    output logic [IN_W*LANES-1:0]      o_out_data,
    output logic [LANES-1:0]           o_out_keep,
    output logic                       o_out_vld,
    input  logic                       i_out_rdy,
`ifdef DATA_PACK_STAT_EN
    output logic [15:0]                o_word_cnt,
    output logic [15:0]                o_flush_cnt,
`endif
    output logic [$clog2(LANES+1)-1:0] o_lane_cnt
);

    localparam int CW = $clog2(LANES + 1);
    localparam int OW = IN_W * LANES;

    // Lane counter (0..LANES-1) and the held lanes. The final lane never
    // needs storage: the beat that fills it goes straight to the output.
    logic [CW-1:0]   cnt;
    logic [IN_W-1:0] acc [LANES-1];

    logic            in_rdy;
    logic            accept;
    logic            complete;
    logic            flush_do;
    logic            load;
    logic [CW-1:0]   eff_cnt;
    logic [IN_W-1:0] lane_val [LANES];
    logic [LANES-1:0] lane_keep;
    logic [OW-1:0]   next_data;
    logic [LANES-1:0] next_keep;

    // Handshake and control decode. A flush only counts when the packer
    // is able to take a beat, and it never turns a completing beat into a
    // partial word. The effective count includes a beat accepted in the
    // same cycle, so a flush can carry that beat out with it.
    always_comb begin
        in_rdy   = !o_out_vld || i_out_rdy;
        accept   = i_wren && in_rdy && !i_sync;
        complete = accept && (cnt == CW'(LANES - 1));
        eff_cnt  = cnt + CW'(accept);
        flush_do = i_flush && in_rdy && !i_sync && !complete && (eff_cnt != '0);
        load     = complete || flush_do;
    end

    // Build the candidate output word in logical lane order first, where
    // lane 0 holds the first beat. It is then mapped onto bit positions.
    // Lanes at or beyond the effective count get PAD and keep 0. A full
    // word has an effective count of LANES, which gives an all-ones mask.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_val[k] = PAD;
        end
        for (int k = 0; k < LANES - 1; k++) begin
            if (CW'(k) < cnt) begin
                lane_val[k] = acc[k];
            end
        end
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (CW'(k) == cnt) begin
                    lane_val[k] = i_data;
                end
            end
        end
        lane_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_keep[k] = (CW'(k) < eff_cnt);
        end
    end

    // Map logical lanes onto output bit positions. With MSB_FIRST set,
    // logical lane 0 occupies the top IN_W bits. The keep mask follows
    // the same ordering as the data.
    always_comb begin
        next_data = '0;
        next_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            if (MSB_FIRST != 0) begin
                next_data[(LANES-1-k)*IN_W +: IN_W] = lane_val[k];
                next_keep[LANES-1-k]                = lane_keep[k];
            end else begin
                next_data[k*IN_W +: IN_W] = lane_val[k];
                next_keep[k]              = lane_keep[k];
            end
        end
    end

    // Lane counter. Sync has priority and restarts alignment. A completed
    // or flushed word also restarts it. Otherwise each accepted beat
    // advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (i_sync || load) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Accumulator storage. A non-completing beat is written into the lane
    // the counter points at. Contents past the counter are don't-care,
    // because the counter masks them when the word is built.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES - 1; k++) begin
                acc[k] <= '0;
            end
        end else if (accept && !complete) begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (CW'(k) == cnt) begin
                    acc[k] <= i_data;
                end
            end
        end
    end

    // Output register. A load always wins, including when the previous
    // word drains in the same cycle, so valid stays high with the new
    // word. Without a load, a completed handshake drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_out_data <= '0;
            o_out_keep <= '0;
            o_out_vld  <= 1'b0;
        end else if (load) begin
            o_out_data <= next_data;
            o_out_keep <= next_keep;
            o_out_vld  <= 1'b1;
        end else if (o_out_vld && i_out_rdy) begin
            o_out_vld  <= 1'b0;
        end
    end

`ifdef DATA_PACK_STAT_EN
    // Statistics. These counters deliberately survive i_sync, so a capture
    // session can be realigned without losing its word totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_word_cnt  <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (complete) begin
                o_word_cnt <= o_word_cnt + 16'd1;
            end
            if (flush_do) begin
                o_flush_cnt <= o_flush_cnt + 16'd1;
            end
        end
    end
`endif

    assign o_in_rdy   = in_rdy;
    assign o_lane_cnt = cnt;

endmodule
